// File: rtl/mux_share_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 datapath mux: registered one-hot
// grant, matching select, and a burst limit so one owner cannot starve the rest.
module mux_share_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [CNT_W-1:0] owner_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] others_s;
    logic       own_req_s;
    logic       keep_s;
    logic [2:0] pick_all_s;
    logic [2:0] pick_oth_s;

    // Scan from p upward (mod 4); returns {found, index} of the first set bit.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + k[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration candidates for the idle and owned cases.
    always_comb begin
        others_s   = req & ~gnt_q;
        own_req_s  = req[sel_q];
        keep_s     = own_req_s && ((cnt_q < MAX_CNT) || (others_s == 4'b0000));
        pick_all_s = rr_pick(req, ptr_q);
        pick_oth_s = rr_pick(others_s, ptr_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_all_s[2]) begin
                    state_d = ST_OWNED;
                    gnt_d   = 4'b0001 << pick_all_s[1:0];
                    sel_d   = pick_all_s[1:0];
                    valid_d = 1'b1;
                    cnt_d   = CNT_ONE;
                    ptr_d   = pick_all_s[1:0] + 2'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (keep_s) begin
                    if (cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (pick_oth_s[2]) begin
                    // Release or forced handoff: move straight to the next owner, no bubble.
                    gnt_d = 4'b0001 << pick_oth_s[1:0];
                    sel_d = pick_oth_s[1:0];
                    cnt_d = CNT_ONE;
                    ptr_d = pick_oth_s[1:0] + 2'd1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign valid     = valid_q;
    assign owner_cnt = cnt_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed self-checking bench for mux_share_arbiter with MAX_BURST=4.
module tb_mux_share_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [2:0] owner_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mux_share_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .valid     (valid),
        .owner_cnt (owner_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with the given request pattern, release after an edge.
    task automatic do_reset(input logic [3:0] r);
        reset_n = 1'b0;
        req     = r;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(4'b1111);
        n_checks++;
        if ({gnt, sel, valid, owner_cnt} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b sel=%0d valid=%b cnt=%0d, want all zero", gnt, sel, valid, owner_cnt);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || valid !== 1'b1 || owner_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL first_grant: got gnt=%b sel=%0d valid=%b cnt=%0d, want 0001/0/1/1", gnt, sel, valid, owner_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [1:0] es;
        logic [2:0] ec;
        do_reset(4'b1111);
        for (int i = 0; i < 17; i++) begin
            step();
            es = 2'((i / 4) % 4);
            eg = 4'b0001 << es;
            ec = 3'((i % 4) + 1);
            n_checks++;
            if (gnt !== eg || sel !== es || owner_cnt !== ec || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got gnt=%b sel=%0d cnt=%0d valid=%b, want %b/%0d/%0d/1", i, gnt, sel, owner_cnt, valid, eg, es, ec);
            end
        end
    endtask

    task automatic test_solo_saturation();
        logic [2:0] ec;
        do_reset(4'b0100);
        for (int k = 1; k <= 10; k++) begin
            step();
            ec = (k < 4) ? 3'(k) : 3'd4;
            n_checks++;
            if (gnt !== 4'b0100 || sel !== 2'd2 || owner_cnt !== ec) begin
                n_fail++;
                $display("FAIL solo_sat[%0d]: got gnt=%b sel=%0d cnt=%0d, want 0100/2/%0d", k, gnt, sel, owner_cnt, ec);
            end
        end
    endtask

    task automatic test_release_handoff();
        do_reset(4'b0010);
        step();
        req = 4'b1010;
        step();
        n_checks++;
        if (gnt !== 4'b0010 || owner_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL handoff_setup: got gnt=%b cnt=%0d, want 0010/2", gnt, owner_cnt);
        end
        req = 4'b1000;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || owner_cnt !== 3'd1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_handoff: got gnt=%b sel=%0d cnt=%0d valid=%b, want 1000/3/1/1", gnt, sel, owner_cnt, valid);
        end
    endtask

    task automatic test_release_idle();
        do_reset(4'b0100);
        step();
        req = 4'b0000;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || owner_cnt !== 3'd0 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL release_idle: got gnt=%b valid=%b cnt=%0d sel=%0d, want 0000/0/0/2", gnt, valid, owner_cnt, sel);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0000 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL idle_hold: got gnt=%b sel=%0d, want 0000/2", gnt, sel);
        end
        req = 4'b0001;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || valid !== 1'b1 || owner_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL idle_regrant: got gnt=%b sel=%0d valid=%b cnt=%0d, want 0001/0/1/1", gnt, sel, valid, owner_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] eg;
        do_reset(4'b0101);
        for (int i = 0; i < 10; i++) begin
            step();
            eg = (((i / 4) % 2) == 0) ? 4'b0001 : 4'b0100;
            n_checks++;
            if (gnt !== eg || owner_cnt !== 3'((i % 4) + 1)) begin
                n_fail++;
                $display("FAIL skip_idle_req[%0d]: got gnt=%b cnt=%0d, want %b/%0d", i, gnt, owner_cnt, eg, (i % 4) + 1);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset(4'b1000);
        step();
        step();
        step();
        n_checks++;
        if (gnt !== 4'b1000 || owner_cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL midburst_setup: got gnt=%b cnt=%0d, want 1000/3", gnt, owner_cnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || owner_cnt !== 3'd0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b valid=%b cnt=%0d sel=%0d, want 0000/0/0/0", gnt, valid, owner_cnt, sel);
        end
        req = 4'b1111;
        step();
        reset_n = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || owner_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL ptr_after_reset: got gnt=%b sel=%0d cnt=%0d, want 0001/0/1", gnt, sel, owner_cnt);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        test_reset();
        test_round_robin();
        test_solo_saturation();
        test_release_handoff();
        test_release_idle();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 datapath mux (e.g. a shared writeback or memory-result path) among four requesters.
- Registers a one-hot grant and drives the matching 2-bit mux select, so the mux output always belongs to exactly one owner.
- Enforces a maximum burst length so that no requester can starve the others.
- Sits beside the mux in the pipeline control logic; the mux stays purely combinational.

Parameters:
- MAX_BURST, default 4: maximum consecutive cycles one owner may hold the grant while another requester is waiting; legal range is 1 or more.
- CNT_W, default $clog2(MAX_BURST+1): width of the burst counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; bit i set means requester i wants the mux
- gnt  output  4  registered one-hot grant, or all zero
- sel  output  2  registered mux select; equals the index of the set gnt bit
- valid  output  1  registered; high when exactly one gnt bit is set
- owner_cnt  output  CNT_W  cycles the current owner has held the grant, counting the current cycle

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately even mid-burst):
  - Outputs: gnt=0000, sel=00, valid=0, owner_cnt=0.
  - Internal state: rotating pointer ptr=0, state=IDLE.
  - Reset release is synchronous to clk; the first arbitration happens at the first rising edge after release.
- State machine has two states, IDLE and OWNED.
- Arbitration function:
  - Scan requesters ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
  - The first set req bit wins.
  - In OWNED, the current owner is excluded from the scan when the handoff is forced.
- IDLE:
  - req=0000: stay in IDLE, outputs unchanged at zero.
  - Any req set: at the next edge go to OWNED with gnt=onehot(winner), sel=winner, valid=1, owner_cnt=1.
- OWNED, with o as the current owner:
  - Keep: req[o]=1 and (owner_cnt<MAX_BURST or no other req set).
    - Grant is held.
    - owner_cnt increments and saturates at MAX_BURST.
  - Release: req[o]=0.
    - If another req is set, the grant moves directly to the winner at the next edge with no bubble; owner_cnt=1.
    - Otherwise go to IDLE with gnt=0000, valid=0, owner_cnt=0, and sel holding its last value.
  - Forced handoff: req[o]=1, owner_cnt=MAX_BURST, and some other req set.
    - The grant moves to the winner among the others at the next edge; owner_cnt=1.
- Pointer: on every new grant to requester w, ptr becomes (w+1) mod 4, so the winner becomes lowest priority next time.
- Latency: a request is granted no earlier than the edge after it is sampled. Worst-case wait is 3*MAX_BURST cycles plus 1.
- Simultaneous events: several new requests in the same cycle are resolved purely by ptr order. A release and a new request in the same cycle produce a direct handoff.
- Invariants, checked every cycle:
  - gnt is one-hot or zero.
  - valid equals the OR of the gnt bits.
  - When valid=1, sel equals the index of the set gnt bit.
- MAX_BURST=1 gives strict per-cycle round robin whenever there is contention.

Test Plan:
- Reset and first grant:
  - Stimulus: assert reset_n=0 with req=1111, then release.
  - Required: outputs zero during reset. One cycle after release, gnt=0001, sel=00, valid=1, owner_cnt=1.
- Round-robin order: hold req=1111 with MAX_BURST=4.
  - Required: gnt sequence is 0001 for 4 cycles, then 0010 for 4, 0100 for 4, 1000 for 4, then back to 0001.
  - sel follows as 0, 1, 2, 3; owner_cnt counts 1 to 4 in each burst.
- Solo owner saturation: hold req=0100 for 10 cycles.
  - Required: gnt stays 0100 for all 10 cycles; owner_cnt saturates at 4; no handoff.
- Release with direct handoff:
  - Stimulus: owner 1 with owner_cnt=2 drops req[1] while req[3]=1.
  - Required: next cycle gnt=1000, sel=11, owner_cnt=1, with no valid=0 bubble.
- Release to idle:
  - Stimulus: owner 2 drops req while all other req bits are 0.
  - Required: next cycle gnt=0000, valid=0, owner_cnt=0, sel stays 10. A later req=0001 grants requester 0 one cycle after it is asserted.
- Reset mid-burst:
  - Stimulus: owner 3 with owner_cnt=3 sees reset_n pulled low between edges.
  - Required: gnt=0000, valid=0, owner_cnt=0 immediately, without waiting for a clock edge. After release with req=1111, the first grant goes to 0001, confirming ptr was reset to 0.
